// File: rtl/lane_note_renderer.sv
// Multi-lane falling-note overlay for the 480x272 LCD pixel stream: note state per lane,
// frame-rate advance, hit flash, and a two-stage colour pipeline. Optional track drawing via LANE_TRACK_EN.
module lane_note_renderer #(
  parameter int LANES        = 4,
  parameter int H_W          = 10,
  parameter int V_W          = 9,
  parameter int LANE_X0      = 40,
  parameter int LANE_PITCH   = 100,
  parameter int BAR_W        = 20,
  parameter int NOTE_H       = 16,
  parameter int V_ACTIVE     = 272,
  parameter int SPEED        = 2,
  parameter int FLASH_FRAMES = 8,
  parameter int COLOR_W      = 1,
  localparam int LW          = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk_lcd,
  input  logic               rst_n,
  input  logic               flagh,
  input  logic               flagv,
  input  logic               rgb_en,
  input  logic [H_W-1:0]     hcount_reg,
  input  logic [V_W-1:0]     Vcount_reg,
  input  logic [H_W-1:0]     offset,
  input  logic               note_valid,
  output logic               note_ready,
  input  logic [LW-1:0]      note_lane,
  input  logic [LANES-1:0]   hit,
  output logic [LANES-1:0]   miss,
  output logic [COLOR_W-1:0] data_RED,
  output logic [COLOR_W-1:0] data_GREEN,
  output logic [COLOR_W-1:0] data_BLUE
);

  localparam int FL_W = $clog2(FLASH_FRAMES + 1);
  localparam int XW   = H_W + 2;

  logic [LANES-1:0] active;
  logic [V_W-1:0]   y     [LANES];
  logic [FL_W-1:0]  flash [LANES];
  logic [V_W:0]     y_adv [LANES];
  logic             flagv_q;
  logic             frame_tick;
  logic             lane_ok;
  logic             spawn;

  // Handshake: a note transfers on any clock where note_valid && note_ready;
  // ready is low exactly while the addressed lane still holds a note.
  assign lane_ok    = ({1'b0, note_lane} < (LW + 1)'(LANES));
  assign note_ready = lane_ok && !active[note_lane];
  assign spawn      = note_valid && note_ready;
  assign frame_tick = flagv_q && !flagv;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      y_adv[i] = {1'b0, y[i]} + (V_W + 1)'(SPEED);
    end
  end

  always_ff @(posedge clk_lcd) begin
    if (!rst_n) begin
      active  <= '0;
      miss    <= '0;
      flagv_q <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        y[i]     <= '0;
        flash[i] <= '0;
      end
    end else begin
      flagv_q <= flagv;
      miss    <= '0;
      for (int i = 0; i < LANES; i++) begin
        // A hit on a live note takes precedence over that lane's frame advance.
        if (hit[i] && active[i]) begin
          active[i] <= 1'b0;
          flash[i]  <= FL_W'(FLASH_FRAMES);
        end else begin
          if (frame_tick && (flash[i] != '0)) begin
            flash[i] <= flash[i] - 1'b1;
          end
          if (frame_tick && active[i]) begin
            if (y_adv[i] >= (V_W + 1)'(V_ACTIVE)) begin
              active[i] <= 1'b0;
              miss[i]   <= 1'b1;
            end else begin
              y[i] <= y_adv[i][V_W-1:0];
            end
          end
        end
      end
      if (spawn) begin
        active[note_lane] <= 1'b1;
        y[note_lane]      <= '0;
      end
    end
  end

  logic [COLOR_W-1:0] col_r, col_g, col_b;
  logic               found;
  logic [XW-1:0]      x_pix, x_lo;
  logic [V_W:0]       v_pix, y_lo;
  logic               in_col, in_row;

  // The lowest-index lane whose column covers the pixel owns its colour.
  always_comb begin
    col_r  = '0;
    col_g  = '0;
    col_b  = '0;
    found  = 1'b0;
    x_pix  = {2'b00, hcount_reg};
    v_pix  = {1'b0, Vcount_reg};
    x_lo   = '0;
    y_lo   = '0;
    in_col = 1'b0;
    in_row = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      x_lo   = XW'(LANE_X0) + XW'(i * LANE_PITCH) + {2'b00, offset};
      y_lo   = {1'b0, y[i]};
      in_col = (x_pix >= x_lo) && (x_pix < x_lo + XW'(BAR_W));
      in_row = active[i] && (v_pix >= y_lo) && (v_pix < y_lo + (V_W + 1)'(NOTE_H));
      if (!found && in_col) begin
        found = 1'b1;
        if (in_row) begin
          col_r = '1;
          col_g = '1;
          col_b = '1;
        end else if (flash[i] != '0) begin
          col_g = '1;
        end else begin
`ifdef LANE_TRACK_EN
          col_b = '1;
`else
          col_b = '0;
`endif
        end
      end
    end
  end

  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  always_ff @(posedge clk_lcd) begin
    if (!rst_n) begin
      pix_r      <= '0;
      pix_g      <= '0;
      pix_b      <= '0;
      data_RED   <= '0;
      data_GREEN <= '0;
      data_BLUE  <= '0;
    end else begin
      pix_r <= (flagh && flagv) ? col_r : '0;
      pix_g <= (flagh && flagv) ? col_g : '0;
      pix_b <= (flagh && flagv) ? col_b : '0;
      if (rgb_en) begin
        data_RED   <= pix_r;
        data_GREEN <= pix_g;
        data_BLUE  <= pix_b;
      end
    end
  end

endmodule

// File: tb/tb_lane_note_renderer.sv
// Directed + randomized bench for lane_note_renderer with a frame-level lane model.
module tb_lane_note_renderer;

  localparam int LANES        = 4;
  localparam int LANE_X0      = 40;
  localparam int LANE_PITCH   = 100;
  localparam int BAR_W        = 20;
  localparam int NOTE_H       = 16;
  localparam int V_ACTIVE     = 272;
  localparam int SPEED        = 2;
  localparam int FLASH_FRAMES = 8;

  logic       clk_lcd = 1'b0;
  logic       rst_n, flagh, flagv, rgb_en;
  logic [9:0] hcount_reg, offset;
  logic [8:0] Vcount_reg;
  logic       note_valid, note_ready;
  logic [1:0] note_lane;
  logic [3:0] hit, miss;
  logic       data_RED, data_GREEN, data_BLUE;

  always #5 clk_lcd = ~clk_lcd;

  lane_note_renderer dut (
    .clk_lcd(clk_lcd), .rst_n(rst_n), .flagh(flagh), .flagv(flagv), .rgb_en(rgb_en),
    .hcount_reg(hcount_reg), .Vcount_reg(Vcount_reg), .offset(offset),
    .note_valid(note_valid), .note_ready(note_ready), .note_lane(note_lane),
    .hit(hit), .miss(miss),
    .data_RED(data_RED), .data_GREEN(data_GREEN), .data_BLUE(data_BLUE)
  );

  // Reference state: what each lane holds, in frame-level terms.
  int         m_active [LANES];
  int         m_y      [LANES];
  int         m_flash  [LANES];
  bit         m_flagv_q;
  logic [2:0] m_data;
  logic [3:0] m_miss;
  logic [2:0] exp_q[$];
  int         n_cmp, n_err, miss0_seen;

`ifdef LANE_TRACK_EN
  localparam logic [2:0] IDLE_COL = 3'b001;
`else
  localparam logic [2:0] IDLE_COL = 3'b000;
`endif

  function automatic logic [2:0] ref_pix();
    int x, v, x0;
    if (!(flagh && flagv)) return 3'b000;
    x = int'(hcount_reg);
    v = int'(Vcount_reg);
    for (int i = 0; i < LANES; i++) begin
      x0 = LANE_X0 + i * LANE_PITCH + int'(offset);
      if (x >= x0 && x < x0 + BAR_W) begin
        if (m_active[i] != 0 && v >= m_y[i] && v < m_y[i] + NOTE_H) return 3'b111;
        if (m_flash[i] > 0) return 3'b010;
        return IDLE_COL;
      end
    end
    return 3'b000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_active[i] = 0;
      m_y[i]      = 0;
      m_flash[i]  = 0;
    end
    m_flagv_q = 1'b0;
    m_data    = 3'b000;
    m_miss    = 4'b0000;
    exp_q     = {3'b000};
  endtask

  // One clock: check combinational ready, advance the model with the DUT, check registered outputs.
  task automatic step();
    logic [2:0] c1, old;
    logic [3:0] hit_v;
    bit         tick, acc;
    int         lane;
    #1;
    chk("note_ready", 32'(note_ready), 32'(m_active[note_lane] == 0));
    c1    = ref_pix();
    tick  = m_flagv_q && !flagv;
    acc   = note_valid && (m_active[note_lane] == 0);
    lane  = int'(note_lane);
    hit_v = hit;
    @(posedge clk_lcd);
    if (!rst_n) begin
      model_reset();
    end else begin
      old = exp_q.pop_front();
      if (rgb_en) m_data = old;
      exp_q.push_back(c1);
      m_miss = 4'b0000;
      for (int i = 0; i < LANES; i++) begin
        if (hit_v[i] && m_active[i] != 0) begin
          m_active[i] = 0;
          m_flash[i]  = FLASH_FRAMES;
        end else begin
          if (tick && m_flash[i] > 0) m_flash[i]--;
          if (tick && m_active[i] != 0) begin
            if (m_y[i] + SPEED >= V_ACTIVE) begin
              m_active[i] = 0;
              m_miss[i]   = 1'b1;
            end else begin
              m_y[i] += SPEED;
            end
          end
        end
      end
      if (acc) begin
        m_active[lane] = 1;
        m_y[lane]      = 0;
      end
      m_flagv_q = flagv;
    end
    #1;
    chk("data", 32'({data_RED, data_GREEN, data_BLUE}), 32'(m_data));
    chk("miss", 32'(miss), 32'(m_miss));
    if (miss[0]) miss0_seen++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // Short frames: three active cycles then one blanking cycle (one frame_tick each).
  task automatic frames(input int n, input bit rnd_pix);
    repeat (n) begin
      flagv = 1'b1;
      repeat (3) begin
        if (rnd_pix) begin
          hcount_reg = 10'($urandom_range(0, 479));
          Vcount_reg = 9'($urandom_range(0, 271));
        end
        step();
      end
      flagv = 1'b0;
      step();
    end
    flagv = 1'b1;
  endtask

  task automatic spawn(input int lane);
    note_valid = 1'b1;
    note_lane  = 2'(lane);
    step();
    note_valid = 1'b0;
  endtask

  logic [2:0] held;

  initial begin
    n_cmp = 0; n_err = 0; miss0_seen = 0;
    model_reset();
    flagh = 1'b1; flagv = 1'b1; rgb_en = 1'b1;
    hcount_reg = '0; Vcount_reg = '0; offset = '0;
    note_valid = 1'b0; note_lane = '0; hit = '0;

    // Reset values.
    do_reset();
    chk("rst_data", 32'({data_RED, data_GREEN, data_BLUE}), 32'(3'b000));
    chk("rst_miss", 32'(miss), 32'(0));
    chk("rst_ready", 32'(note_ready), 32'(1));

    // Spawn in lane 2 is drawn white at (240,5) two cycles later; lane is then busy.
    hcount_reg = 10'd240; Vcount_reg = 9'd5;
    spawn(2);
    step(); step();
    chk("spawn_white", 32'({data_RED, data_GREEN, data_BLUE}), 32'(3'b111));
    note_valid = 1'b1; note_lane = 2'd2;
    #1 chk("busy_ready", 32'(note_ready), 32'(0));
    note_valid = 1'b0;

    // Lane 0 falls off the bottom on the 136th frame_tick.
    do_reset();
    spawn(0);
    miss0_seen = 0;
    frames(135, 1'b1);
    chk("miss_early", 32'(miss0_seen), 32'(0));
    frames(1, 1'b1);
    chk("miss_once", 32'(miss0_seen), 32'(1));
    note_lane = 2'd0;
    #1 chk("ready_after_miss", 32'(note_ready), 32'(1));

    // Hit on live lane 1: green for the flash window, then idle colour.
    do_reset();
    spawn(1);
    hcount_reg = 10'd145; Vcount_reg = 9'd200;
    hit = 4'b0010; step(); hit = 4'b0000;
    step(); step();
    chk("flash_green", 32'({data_RED, data_GREEN, data_BLUE}), 32'(3'b010));
    frames(FLASH_FRAMES, 1'b0);
    step(); step();
    chk("flash_done", 32'({data_RED, data_GREEN, data_BLUE}), 32'(IDLE_COL));
    // Hit on idle lane 3 starts no flash.
    hcount_reg = 10'd345;
    hit = 4'b1000; step(); hit = 4'b0000;
    step(); step();
    chk("idle_hit", 32'({data_RED, data_GREEN, data_BLUE}), 32'(IDLE_COL));

    // Hit on lane 0 together with its final frame_tick: no miss, flash starts.
    do_reset();
    spawn(0);
    frames(135, 1'b1);
    miss0_seen = 0;
    hcount_reg = 10'd45; Vcount_reg = 9'd200;
    flagv = 1'b1; repeat (3) step();
    flagv = 1'b0; hit = 4'b0001; step();
    hit = 4'b0000; flagv = 1'b1;
    step(); step();
    chk("hit_vs_miss", 32'(miss0_seen), 32'(0));
    chk("hit_tick_flash", 32'({data_RED, data_GREEN, data_BLUE}), 32'(3'b010));

    // rgb_en low freezes the output registers.
    do_reset();
    spawn(1);
    hcount_reg = 10'd150; Vcount_reg = 9'd3;
    step(); step();
    rgb_en = 1'b0;
    held = {data_RED, data_GREEN, data_BLUE};
    repeat (10) begin
      hcount_reg = 10'($urandom_range(0, 479));
      step();
      chk("frozen", 32'({data_RED, data_GREEN, data_BLUE}), 32'(held));
    end
    rgb_en = 1'b1;

    // offset = 15 moves lane 0's white span to x = 55..74.
    spawn(0);
    offset = 10'd15; Vcount_reg = 9'd3;
    for (int x = 50; x <= 80; x++) begin
      hcount_reg = 10'(x);
      step(); step();
      chk("offset_span", 32'({data_RED, data_GREEN, data_BLUE} == 3'b111), 32'(x >= 55 && x <= 74));
    end

    // Randomized traffic, including a reset in the middle of a frame.
    for (int k = 0; k < 1500; k++) begin
      int ln;
      ln         = $urandom_range(0, LANES - 1);
      flagv      = ($urandom_range(0, 5) != 0);
      flagh      = ($urandom_range(0, 7) != 0);
      rgb_en     = ($urandom_range(0, 5) != 0);
      offset     = 10'($urandom_range(0, 30));
      hcount_reg = 10'(LANE_X0 + ln * LANE_PITCH + int'(offset) + $urandom_range(0, BAR_W + 4) - 2);
      Vcount_reg = 9'($urandom_range(0, 60));
      note_valid = ($urandom_range(0, 3) == 0);
      note_lane  = 2'($urandom_range(0, LANES - 1));
      hit        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      rst_n      = (k != 700);
      step();
    end
    rst_n = 1'b1; hit = '0; note_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
